// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter that forwards one payload at a time over a 4-phase req/ack handshake.
// Define CDC_HS_TIMEOUT_EN to abort a handshake whose ack never arrives (reported on req_err).
module cdc_hs_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       xfer_req,
    output logic [DATA_W-1:0]          xfer_data,
    input  logic                       ack_sync,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("cdc_hs_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [IDX_W-1:0] gnt_next;
    logic             xreq_next;
    logic [DATA_W-1:0] xdata_next;
    logic [NUM_REQ-1:0] ready_next, done_next;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [DATA_W-1:0] req_word [NUM_REQ];

    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign req_word[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Search starts at ptr so the requester after the last winner has top priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid[wrap_idx(int'(ptr), k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(int'(ptr), k);
            end
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [NUM_REQ-1:0] err_next;
    logic               timed_out;

    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gnt_next   = gnt_id;
        xreq_next  = xfer_req;
        xdata_next = xfer_data;
        ready_next = '0;
        done_next  = '0;
`ifdef CDC_HS_TIMEOUT_EN
        cnt_next   = '0;
        err_next   = '0;
`endif
        unique case (state)
            IDLE: begin
                // A still-high ack belongs to an aborted transfer; never start over it.
                if (pick_found && !ack_sync) begin
                    state_next = REQ_HI;
                    ptr_next   = wrap_idx(int'(pick_idx), 1);
                    gnt_next   = pick_idx;
                    xreq_next  = 1'b1;
                    xdata_next = req_word[pick_idx];
                    ready_next = onehot(pick_idx);
                end
            end
            REQ_HI: begin
                if (ack_sync) begin
                    state_next = REQ_LO;
                    xreq_next  = 1'b0;
                end
`ifdef CDC_HS_TIMEOUT_EN
                else if (timed_out) begin
                    state_next = IDLE;
                    xreq_next  = 1'b0;
                    err_next   = onehot(gnt_id);
                end else begin
                    cnt_next   = cnt + 1'b1;
                end
`endif
            end
            REQ_LO: begin
                if (!ack_sync) begin
                    state_next = IDLE;
                    done_next  = onehot(gnt_id);
                end
`ifdef CDC_HS_TIMEOUT_EN
                else if (timed_out) begin
                    state_next = IDLE;
                    err_next   = onehot(gnt_id);
                end else begin
                    cnt_next   = cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_next = IDLE;
                xreq_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_id    <= '0;
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            req_ready <= '0;
            req_done  <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            gnt_id    <= gnt_next;
            xfer_req  <= xreq_next;
            xfer_data <= xdata_next;
            req_ready <= ready_next;
            req_done  <= done_next;
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            req_err <= '0;
        end else begin
            cnt     <= cnt_next;
            req_err <= err_next;
        end
    end
`else
    assign req_err = '0;
`endif

    assign busy = (state != IDLE);

endmodule
